// File: rtl/ir_fetch_seq.sv
// Instruction register that assembles NBYTES-wide instructions from byte-wide memory reads.
// Optional macro IR_MSB_FIRST_EN: fetched bytes fill slots from the most significant down.
module ir_fetch_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NBYTES = 2,
  localparam int unsigned IR_W  = DATA_W * NBYTES,
  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Flush,
  input  logic [DATA_W-1:0] Data,
  input  logic              DataValid,
  input  logic              Enable,
  input  logic [1:0]        FunSel,
  input  logic [IDX_W-1:0]  ByteSel,
  output logic [IR_W-1:0]   IROut,
  output logic              MemReq,
  output logic [IDX_W-1:0]  ByteIdx,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e             state_q, state_d;
  logic [IR_W-1:0]    ir_q, ir_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   fetch_slot;

  // Physical slot written by a fetched byte; the ByteIdx count itself is order-independent.
`ifdef IR_MSB_FIRST_EN
  assign fetch_slot = IDX_W'(NBYTES - 1) - idx_q;
`else
  assign fetch_slot = idx_q;
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StFetch;
          idx_d   = '0;
        end else if (Enable) begin
          unique case (FunSel)
            2'b00: ir_d = '0;
            2'b01: begin
              // Out-of-range ByteSel matches no slot, so nothing is written.
              for (int unsigned s = 0; s < NBYTES; s++) begin
                if (ByteSel == IDX_W'(s)) ir_d[s*DATA_W +: DATA_W] = Data;
              end
            end
            2'b10: ir_d = ir_q - IR_W'(1);
            2'b11: ir_d = ir_q + IR_W'(1);
            default: ir_d = ir_q;
          endcase
        end
      end
      StFetch: begin
        if (Flush) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (DataValid) begin
          for (int unsigned s = 0; s < NBYTES; s++) begin
            if (fetch_slot == IDX_W'(s)) ir_d[s*DATA_W +: DATA_W] = Data;
          end
          if (idx_q == IDX_W'(NBYTES - 1)) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign IROut   = ir_q;
  assign MemReq  = (state_q == StFetch);
  assign Busy    = MemReq;
  assign ByteIdx = idx_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_ir_fetch_seq.sv
// Self-checking bench for ir_fetch_seq: byte-array reference model plus directed literal checks.
module tb_ir_fetch_seq;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NBYTES = 2;
  localparam int unsigned IR_W   = DATA_W * NBYTES;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
`ifdef IR_MSB_FIRST_EN
  localparam bit MsbFirst = 1'b1;
`else
  localparam bit MsbFirst = 1'b0;
`endif

  logic              Clock = 1'b0;
  logic              Reset, Start, Flush, DataValid, Enable;
  logic [DATA_W-1:0] Data;
  logic [1:0]        FunSel;
  logic [IDX_W-1:0]  ByteSel;
  logic [IR_W-1:0]   IROut;
  logic              MemReq, Busy, Done;
  logic [IDX_W-1:0]  ByteIdx;

  ir_fetch_seq #(.DATA_W(DATA_W), .NBYTES(NBYTES)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Flush(Flush), .Data(Data),
    .DataValid(DataValid), .Enable(Enable), .FunSel(FunSel), .ByteSel(ByteSel),
    .IROut(IROut), .MemReq(MemReq), .ByteIdx(ByteIdx), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction held as a byte-addressed value, fetch tracked as a count.
  logic [IR_W-1:0] m_ir = '0;
  bit              m_fetching = 1'b0;
  int              m_got = 0;
  bit              m_done = 1'b0;

  always @(posedge Clock) begin
    int pos;
    if (!Reset) begin
      m_ir = '0; m_fetching = 1'b0; m_got = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_fetching) begin
        if (Start) begin
          m_fetching = 1'b1; m_got = 0;
        end else if (Enable) begin
          case (FunSel)
            2'b00: m_ir = '0;
            2'b01: begin
              pos = int'(ByteSel);
              if (pos < NBYTES) m_ir[pos*DATA_W +: DATA_W] = Data;
            end
            2'b10: m_ir = m_ir - 1;
            default: m_ir = m_ir + 1;
          endcase
        end
      end else if (Flush) begin
        m_fetching = 1'b0; m_got = 0;
      end else if (DataValid) begin
        pos = MsbFirst ? (NBYTES - 1 - m_got) : m_got;
        m_ir[pos*DATA_W +: DATA_W] = Data;
        m_got++;
        if (m_got == NBYTES) begin
          m_fetching = 1'b0; m_got = 0; m_done = 1'b1;
        end
      end
    end
  end

  initial begin
    wait (cmp_en);
    forever begin
      @(negedge Clock);
      chk("cyc_irout", 64'(IROut), 64'(m_ir));
      chk("cyc_memreq", 64'(MemReq), 64'(m_fetching));
      chk("cyc_busy", 64'(Busy), 64'(m_fetching));
      chk("cyc_byteidx", 64'(ByteIdx), 64'(m_got));
      chk("cyc_done", 64'(Done), 64'(m_done));
    end
  end

  task automatic step(input logic rst, input logic st, input logic fl, input logic dv,
                      input logic en, input logic [1:0] fs, input logic [IDX_W-1:0] bs,
                      input logic [DATA_W-1:0] d);
    Reset = rst; Start = st; Flush = fl; DataValid = dv;
    Enable = en; FunSel = fs; ByteSel = bs; Data = d;
    @(negedge Clock);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, 8'h00);
    cmp_en = 1'b1;

    // 1: reset clears a loaded register; Start during reset is ignored
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 8'h34);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 8'h12);
    chk("load_1234", 64'(IROut), 64'h1234);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, 8'h00);
    chk("rst_irout", 64'(IROut), 64'h0);
    chk("rst_memreq", 64'(MemReq), 64'h0);
    chk("rst_done", 64'(Done), 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, 8'h00);
    chk("rst_start_ignored", 64'(Busy), 64'h0);

    // 2: back-to-back fetch, then Start in the Done cycle
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, 8'h00);
    chk("f1_memreq", 64'(MemReq), 64'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, 8'h95);
    chk("f1_idx1", 64'(ByteIdx), 64'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, 8'h02);
    chk("f1_irout", 64'(IROut), MsbFirst ? 64'h9502 : 64'h0295);
    chk("f1_done", 64'(Done), 64'h1);
    chk("f1_memreq_low", 64'(MemReq), 64'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, 8'h00);
    chk("f1_done_pulse", 64'(Done), 64'h0);
    chk("start_in_done", 64'(MemReq), 64'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, '0, 8'h00);

    // 3: gaps in DataValid hold ByteIdx
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, 8'h08);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, 8'hEE);
    chk("gap_idx", 64'(ByteIdx), 64'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, 8'hEE);
    chk("gap_memreq", 64'(MemReq), 64'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, 8'hA0);
    chk("gap_irout", 64'(IROut), MsbFirst ? 64'h08A0 : 64'hA008);
    chk("gap_done", 64'(Done), 64'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, '0, 8'h00);
    chk("flush_idle_noeffect", 64'(Busy), 64'h0);

    // 4: direct ops with wrap-around
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, '0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, '0, 8'h00);
    chk("dec_wrap", 64'(IROut), 64'hFFFF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, '0, 8'h00);
    chk("inc_wrap", 64'(IROut), 64'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, '0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 8'h08);
    chk("load_hi", 64'(IROut), 64'h08FF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, '0, 8'h00);
    chk("en0_hold", 64'(IROut), 64'h08FF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, '0, 8'h00);
    chk("clear", 64'(IROut), 64'h0000);

    // 5: Flush beats DataValid; direct ops ignored during FETCH
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 8'hAB);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, '0, 8'h00);
    chk("start_beats_enable", 64'(IROut), 64'hAB00);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, 8'h55);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, '0, 8'h66);
    chk("flush_irout", 64'(IROut), MsbFirst ? 64'h5500 : 64'hAB55);
    chk("flush_nodone", 64'(Done), 64'h0);
    chk("flush_idle", 64'(MemReq), 64'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, '0, 8'h00);
    chk("fetch_ignores_op", 64'(IROut), MsbFirst ? 64'h5500 : 64'hAB55);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, '0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
